// File: rtl/ssd_scan_driver.sv
// Time-multiplexed seven-segment scan driver with frame-synchronous digit load and blink.
// Optional build macro SSD_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module ssd_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int BLINK_FRAMES = 125
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    scanTick,
  input  logic [4*NUM_DIGITS-1:0] digitsIn,
  input  logic [NUM_DIGITS-1:0]   dpIn,
  input  logic                    blinkEn,
  input  logic                    loadReq,
  output logic                    loadAck,
  output logic                    frameStart,
  output logic [6:0]              ssdCathode,
  output logic                    ssdDp,
  output logic [7:0]              ssdAnode
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLINK_W-1:0] LAST_BLINK = BLINK_W'(BLINK_FRAMES - 1);

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        index_q, index_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic                    acked_q, acked_d;
  logic [BLINK_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                    blink_off_q, blink_off_d;

  logic                    load_ack_q, frame_start_q;
  logic [6:0]              cathode_q, cathode_d;
  logic                    ssd_dp_q, ssd_dp_d;
  logic [7:0]              anode_q, anode_d;

  logic                    boundary;
  logic                    load_fire;
  logic [3:0]              sel_code;
  logic                    sel_dp;
  logic                    blank;
`ifdef SSD_LEADING_ZERO_BLANK_EN
  logic                    all_zero;
`endif

  function automatic logic [6:0] hex_glyph(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Scan sequencing: the IDLE->SCAN tick and every wrap to digit 0 start a frame.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    index_d  = index_q;
    boundary = 1'b0;
    if (scanTick) begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_SCAN;
          index_d  = '0;
          boundary = 1'b1;
        end
        default: begin
          if (index_q == LAST_IDX) begin
            index_d  = '0;
            boundary = 1'b1;
          end else begin
            index_d = index_q + 1'b1;
          end
        end
      endcase
    end
  end

  // A held request is served once; a new one needs loadReq to drop first.
  always_comb begin
    load_fire = boundary && loadReq && !acked_q;
    digits_d  = load_fire ? digitsIn : digits_q;
    dp_d      = load_fire ? dpIn : dp_q;
    if (!loadReq) begin
      acked_d = 1'b0;
    end else if (load_fire) begin
      acked_d = 1'b1;
    end else begin
      acked_d = acked_q;
    end
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;
    if (!blinkEn) begin
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
    end else if (boundary) begin
      if (blink_cnt_q == LAST_BLINK) begin
        blink_cnt_d = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Output image is built from next-state values so a capture shows on digit 0 immediately.
  always_comb begin
    sel_code = 4'h0;
    sel_dp   = 1'b0;
    blank    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (index_d == IDX_W'(i)) begin
        sel_code = digits_d[4*i +: 4];
        sel_dp   = dp_d[i];
      end
    end
`ifdef SSD_LEADING_ZERO_BLANK_EN
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      all_zero = all_zero && (digits_d[4*i +: 4] == 4'h0);
      if (index_d == IDX_W'(i)) begin
        blank = all_zero;
      end
    end
`else
    blank = 1'b0;
`endif
    cathode_d = blank ? 7'h7F : hex_glyph(sel_code);
    ssd_dp_d  = ~sel_dp;
    anode_d   = blink_off_d ? 8'hFF : ~(8'h01 << index_d);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q       <= ST_IDLE;
      index_q       <= '0;
      digits_q      <= '0;
      dp_q          <= '0;
      acked_q       <= 1'b0;
      blink_cnt_q   <= '0;
      blink_off_q   <= 1'b0;
      load_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      digits_q      <= digits_d;
      dp_q          <= dp_d;
      acked_q       <= acked_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_off_q   <= blink_off_d;
      load_ack_q    <= load_fire;
      frame_start_q <= boundary;
    end
  end

  // Display registers change only on a tick so each digit holds for a full slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      cathode_q <= 7'h7F;
      ssd_dp_q  <= 1'b1;
      anode_q   <= 8'hFF;
    end else if (scanTick) begin
      cathode_q <= cathode_d;
      ssd_dp_q  <= ssd_dp_d;
      anode_q   <= anode_d;
    end
  end

  assign loadAck    = load_ack_q;
  assign frameStart = frame_start_q;
  assign ssdCathode = cathode_q;
  assign ssdDp      = ssd_dp_q;
  assign ssdAnode   = anode_q;

endmodule

// File: doc/ssd_scan_driver.md
# ssd_scan_driver

Time-multiplexed seven-segment scan driver for the Nexys4 DDR 8-digit display, placed directly downstream of the reaction-timer FSM digit counters. Captures a packed set of 4-bit digit codes through a frame-synchronous load handshake, so the display never shows a mix of two updates. Decodes one digit per scan tick onto the active-low cathode and anode buses, with optional frame-based blinking and dot control.

## Interface
- NUM_DIGITS, 4: number of scanned digits, 1..8; digit i drives ssdAnode[i].
- BLINK_FRAMES, 125: frames per blink half-period (500 ms at a 1 kHz tick with 4 digits).
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high.
- scanTick  in  1  single-cycle enable pulse, from the 1 kHz divider edge detector.
- digitsIn  in  4*NUM_DIGITS  digit codes; [3:0] is digit 0, the rightmost.
- dpIn  in  NUM_DIGITS  decimal-point request per digit, active-high.
- blinkEn  in  1  level; enables blinking of the whole display.
- loadReq  in  1  level; held high until loadAck is seen.
- loadAck  out  1  one-cycle pulse; digitsIn/dpIn captured this cycle.
- frameStart  out  1  one-cycle pulse at every frame boundary.
- ssdCathode  out  7  active-low segments {g,f,e,d,c,b,a}.
- ssdDp  out  1  active-low decimal point.
- ssdAnode  out  8  active-low digit enables.

## Operation
- States: IDLE (after reset) and SCAN.
- IDLE: display dark. On scanTick: go to SCAN with index = 0. This tick is a frame boundary.
- SCAN: on each scanTick, index = (index == NUM_DIGITS-1) ? 0 : index+1. Wrapping to 0 is a frame boundary.
- Frame boundary actions, all on the same cycle as the tick:
  - frameStart = 1.
  - If loadReq = 1: the shadow registers capture digitsIn and dpIn, and loadAck = 1.
  - If blinkEn = 1: blink counter advances.
- loadReq low at a boundary: shadow registers hold their previous values.
- Handshake: the requester keeps data stable while loadReq is high. It drops loadReq in the cycle after loadAck. loadReq high for several frames is acked only once; the requester must drop it.
- Decode codes 0..F as hex glyphs, taken from the shadow digit at index:
  - 0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 3 = 7'h30, 4 = 7'h19
  - 5 = 7'h12, 6 = 7'h02, 7 = 7'h78, 8 = 7'h00, 9 = 7'h10
  - A = 7'h08, b = 7'h03, C = 7'h46, d = 7'h21, E = 7'h06, F = 7'h0E
- ssdDp = ~shadowDp[index].
- ssdAnode: bit index = 0, all other bits = 1. Bits at or above NUM_DIGITS are always 1.
- Blink:
  - Counter runs 0..BLINK_FRAMES-1. On wrap, blink phase toggles.
  - Phase off forces ssdAnode = 8'hFF.
  - blinkEn = 0 clears the counter and phase (display on) on the next cycle.
- Reset mid-frame: returns to IDLE, dark display. Shadow registers clear to 0. A pending loadReq is not acked; it is served at the first boundary after reset.

## Timing
- All outputs are registered. Reset values:
  - ssdAnode = 8'hFF, ssdCathode = 7'h7F, ssdDp = 1.
  - loadAck = 0, frameStart = 0.
  - index = 0, blink counter = 0, phase = on.
- Anode, cathode and dp change exactly 1 cycle after the scanTick that selects a new index. They hold stable until the next tick.
- loadAck and frameStart are high in the cycle after the boundary tick, for exactly 1 cycle.
- Captured data appears on digit 0 in that same cycle (1-cycle load-to-display latency).
- scanTick while reset = 1 is ignored; reset has priority.

## Configuration
- SSD_LEADING_ZERO_BLANK_EN defined: a digit i > 0 is blanked (ssdCathode = 7'h7F, anode still asserted, dp still driven) when it and every higher shadow digit equal 0. Digit 0 is never blanked.
- Macro undefined: every digit always shows its decoded glyph.

## Test plan
- Reset, then pulse scanTick once with digitsIn = 16'h1234 and loadReq = 1 -> next cycle: loadAck = 1, frameStart = 1, ssdAnode = 8'hFE, ssdCathode = 7'h19.
- Four further ticks -> ssdAnode sequence FD, FB, F7, FE; cathodes 30, 24, 79, 19. frameStart pulses only on the wrap.
- Change digitsIn to 16'h5678 mid-frame with loadReq = 0 -> no visible change. Raise loadReq -> the new value appears only after the next wrap, together with loadAck.
- blinkEn = 1, BLINK_FRAMES = 2 -> anodes all 8'hFF for 2 frames, then active for 2 frames, repeating. Dropping blinkEn restores the display on the next tick.
- Assert reset during digit 2 with loadReq high -> next cycle: ssdAnode = 8'hFF, no loadAck. The first post-reset tick captures the data and acks it.
- With SSD_LEADING_ZERO_BLANK_EN and digitsIn = 16'h0040 -> digits 3 and 2 show 7'h7F, digit 1 shows 7'h19, digit 0 shows 7'h40.
